sc_obstacle_spawner: RTL and testbench

Consumes the 8-bit pseudo-random byte from the LFSR random register and turns it into road-obstacle rows for the Road Fighter playfield. On each game row-advance tick it samples the random byte and decides whether to place one enemy car. It selects the lane, enforces a cooldown gap after every car, and emits a one-hot row pattern to the downstream playfield shift matrix.

---
 rtl/sc_spawner_pkg.sv | 37 +++
 rtl/sc_obstacle_spawner_lane_decoder.sv | 17 +
 rtl/sc_obstacle_spawner.sv | 123 ++++++++++++
 tb/tb_sc_obstacle_spawner.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_spawner_pkg.sv
// Shared types and constants for the Road Fighter obstacle spawner.
package sc_spawner_pkg;

    localparam int unsigned RAND_W  = 8;
    localparam int unsigned LANE_W  = 3;
    localparam int unsigned COOL_W  = 4;
    localparam int unsigned LEVEL_W = 2;
    localparam int unsigned DENS_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        EMIT   = 2'd3
    } state_t;

    localparam logic [DENS_W-1:0] DENSITY_L0 = 4'd2;
    localparam logic [DENS_W-1:0] DENSITY_L1 = 4'd4;
    localparam logic [DENS_W-1:0] DENSITY_L2 = 4'd6;
    localparam logic [DENS_W-1:0] DENSITY_L3 = 4'd8;

    localparam logic [RAND_W-1:0] ROW_EMPTY = 8'h00;

    // Spawn threshold compared against the 3-bit density field of the random byte.
    function automatic logic [DENS_W-1:0] density_threshold(input logic [LEVEL_W-1:0] level);
        logic [DENS_W-1:0] thr;
        thr = DENSITY_L3;
        case (level)
            2'd0:    thr = DENSITY_L0;
            2'd1:    thr = DENSITY_L1;
            2'd2:    thr = DENSITY_L2;
            default: thr = DENSITY_L3;
        endcase
        return thr;
    endfunction

endpackage

// File: rtl/sc_obstacle_spawner_lane_decoder.sv
// 3-to-8 one-hot lane decoder with a zero-force override.
module sc_lane_decoder
    import sc_spawner_pkg::*;
(
    input  logic [LANE_W-1:0] lane,
    input  logic              zero_force,
    output logic [RAND_W-1:0] row_c
);

    always_comb begin
        row_c = ROW_EMPTY;
        if (!zero_force) begin
            row_c[lane] = 1'b1;
        end
    end

endmodule

// File: rtl/sc_obstacle_spawner.sv
// Turns the LFSR random byte into one-hot obstacle rows on each row-advance tick,
// with a density threshold per level and a forced-empty cooldown after each car.
module sc_obstacle_spawner
    import sc_spawner_pkg::*;
#(
    parameter int unsigned DATAWIDTH     = 8,
    parameter int unsigned COOLDOWN_ROWS = 2
) (
    input  logic                 SC_RegRANDOM_CLOCK_50,
    input  logic                 SC_RegRANDOM_RESET_InHigh,
    input  logic [DATAWIDTH-1:0] rand_in,
    input  logic                 tick,
    input  logic                 enable,
    input  logic [LEVEL_W-1:0]   level,
    output logic [DATAWIDTH-1:0] row_out,
    output logic                 row_valid,
    output logic [7:0]           spawn_count,
    output logic                 overrun
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t               state;
    state_t               state_next;
    logic [DATAWIDTH-1:0] rs;
    logic [DATAWIDTH-1:0] rs_next;
    logic [COOL_W-1:0]    cooldown;
    logic [COOL_W-1:0]    cooldown_next;
    logic [DATAWIDTH-1:0] row_next;
    logic                 row_valid_next;
    logic [CNT_W-1:0]     spawn_count_next;
    logic                 overrun_next;
    logic                 spawn_c;
    logic                 zero_force_c;
    logic [RAND_W-1:0]    lane_row_c;
    logic                 unused_rs;

    // Density field is Rs[7:5]; lane is Rs[2:0]; Rs[4:3] carry no meaning.
    assign spawn_c      = {1'b0, rs[7:5]} < density_threshold(level);
    assign zero_force_c = (cooldown != '0) || !spawn_c;
    assign unused_rs    = ^rs[4:3];

    sc_lane_decoder u_lane_decoder (
        .lane       (rs[2:0]),
        .zero_force (zero_force_c),
        .row_c      (lane_row_c)
    );

    always_ff @(posedge SC_RegRANDOM_CLOCK_50 or posedge SC_RegRANDOM_RESET_InHigh) begin
        if (SC_RegRANDOM_RESET_InHigh) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Dropping enable wins over every other transition.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = WAIT;
                WAIT:    state_next = tick ? SAMPLE : WAIT;
                SAMPLE:  state_next = EMIT;
                EMIT:    state_next = WAIT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        rs_next          = rs;
        cooldown_next    = cooldown;
        row_next         = row_out;
        row_valid_next   = 1'b0;
        spawn_count_next = spawn_count;
        overrun_next     = tick && ((state == SAMPLE) || (state == EMIT));

        if (!enable) begin
            row_next      = DATAWIDTH'(ROW_EMPTY);
            cooldown_next = '0;
        end else begin
            case (state)
                SAMPLE: rs_next = rand_in;
                EMIT: begin
                    row_valid_next = 1'b1;
                    row_next       = DATAWIDTH'(lane_row_c);
                    if (cooldown != '0) begin
                        cooldown_next = cooldown - COOL_W'(1);
                    end else if (spawn_c) begin
                        cooldown_next = COOL_W'(COOLDOWN_ROWS);
                        if (spawn_count != CNT_MAX) begin
                            spawn_count_next = spawn_count + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge SC_RegRANDOM_CLOCK_50 or posedge SC_RegRANDOM_RESET_InHigh) begin
        if (SC_RegRANDOM_RESET_InHigh) begin
            rs          <= '0;
            cooldown    <= '0;
            row_out     <= DATAWIDTH'(ROW_EMPTY);
            row_valid   <= 1'b0;
            spawn_count <= '0;
            overrun     <= 1'b0;
        end else begin
            rs          <= rs_next;
            cooldown    <= cooldown_next;
            row_out     <= row_next;
            row_valid   <= row_valid_next;
            spawn_count <= spawn_count_next;
            overrun     <= overrun_next;
        end
    end

endmodule

// File: tb/tb_sc_obstacle_spawner.sv
// Scoreboard bench for sc_obstacle_spawner: expected rows queued at tick time, popped on row_valid.
module tb_sc_obstacle_spawner;
    import sc_spawner_pkg::*;

    localparam int unsigned CLK_HALF  = 10;
    localparam int unsigned COOL_MAIN = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rand_in = 8'h00;
    logic       tick = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] level = 2'd0;

    logic [7:0] row_out;
    logic       row_valid;
    logic [7:0] spawn_count;
    logic       overrun;

    logic [7:0] b_row_out;
    logic       b_row_valid;
    logic [7:0] b_spawn_count;
    logic       b_overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int m_cool = 0;
    int m_count = 0;

    typedef struct {
        logic [7:0] row;
        logic [7:0] cnt;
        int         at;
    } exp_t;
    exp_t exp_q[$];

    sc_obstacle_spawner #(.DATAWIDTH(8), .COOLDOWN_ROWS(COOL_MAIN)) u_dut (
        .SC_RegRANDOM_CLOCK_50     (clk),
        .SC_RegRANDOM_RESET_InHigh (rst),
        .rand_in                   (rand_in),
        .tick                      (tick),
        .enable                    (enable),
        .level                     (level),
        .row_out                   (row_out),
        .row_valid                 (row_valid),
        .spawn_count               (spawn_count),
        .overrun                   (overrun)
    );

    // Zero-cooldown instance used for the saturation scenario.
    sc_obstacle_spawner #(.DATAWIDTH(8), .COOLDOWN_ROWS(0)) u_dut_cd0 (
        .SC_RegRANDOM_CLOCK_50     (clk),
        .SC_RegRANDOM_RESET_InHigh (rst),
        .rand_in                   (rand_in),
        .tick                      (tick),
        .enable                    (enable),
        .level                     (level),
        .row_out                   (b_row_out),
        .row_valid                 (b_row_valid),
        .spawn_count               (b_spawn_count),
        .overrun                   (b_overrun)
    );

    always #CLK_HALF clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour of one EMIT for the COOL_MAIN instance.
    task automatic model_emit(input logic [7:0] r, input logic [1:0] lvl, output logic [7:0] row);
        logic [2:0] d;
        bit         spawn;
        d = r[7:5];
        case (lvl)
            2'd0:    spawn = (d < 3'd2);
            2'd1:    spawn = (d < 3'd4);
            2'd2:    spawn = (d < 3'd6);
            default: spawn = 1'b1;
        endcase
        row = 8'h00;
        if (m_cool != 0) begin
            m_cool--;
        end else if (spawn) begin
            row    = 8'h01 << r[2:0];
            m_cool = COOL_MAIN;
            if (m_count < 255) m_count++;
        end
    endtask

    task automatic do_tick(input logic [7:0] r, input int gap);
        logic [7:0] row;
        exp_t       e;
        rand_in = r;
        tick    = 1'b1;
        model_emit(r, level, row);
        e.row = row;
        e.cnt = 8'(m_count);
        e.at  = cyc + 3;
        exp_q.push_back(e);
        step();
        tick = 1'b0;
        repeat (gap - 1) step();
    endtask

    always @(negedge clk) begin
        if (!rst && row_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_row_valid", 32'(row_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("row_out", 32'(row_out), 32'(e.row));
                check("spawn_count", 32'(spawn_count), 32'(e.cnt));
                check("latency", 32'(cyc), 32'(e.at));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) step();
        check("rst_row_out", 32'(row_out), 32'h00);
        check("rst_row_valid", 32'(row_valid), 32'd0);
        check("rst_spawn_count", 32'(spawn_count), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_b_outputs", 32'({b_row_out, b_row_valid, b_spawn_count, b_overrun}), 32'd0);
        rst = 1'b0;
        step();

        // Tick while idle is ignored.
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("idle_tick_overrun", 32'(overrun), 32'd0);
        check("idle_state", 32'(u_dut.state), 32'(IDLE));
        step();

        // Level 3, constant 0x99: spawn, then cooldown gap, then spawn again.
        enable = 1'b1;
        level  = 2'd3;
        step();
        repeat (4) do_tick(8'h99, 5);
        check("count_after_gap", 32'(spawn_count), 32'd2);
        check("row_after_gap", 32'(row_out), 32'h02);

        // Drain the cooldown, then exercise the level 1 threshold.
        repeat (2) do_tick(8'h99, 3);
        level = 2'd1;
        do_tick(8'h99, 3);
        check("lvl1_no_spawn", 32'(row_out), 32'h00);
        check("lvl1_count_held", 32'(spawn_count), 32'd2);
        do_tick(8'h67, 3);
        check("lane7", 32'(row_out), 32'h80);

        // Back-to-back tick: second one dropped with an overrun pulse.
        rand_in = 8'h67;
        do_tick(8'h67, 1);
        tick = 1'b1;
        check("overrun_n1", 32'(overrun), 32'd0);
        step();
        tick = 1'b0;
        check("overrun_n2", 32'(overrun), 32'd1);
        step();
        check("overrun_n3", 32'(overrun), 32'd0);
        check("valid_n3", 32'(row_valid), 32'd1);
        step();
        step();
        check("single_valid_n5", 32'(row_valid), 32'd0);

        do_tick(8'h00, 3);
        do_tick(8'h67, 3);
        check("pre_drop_row", 32'(row_out), 32'h80);

        // Drop enable the cycle after a tick: pending emit discarded.
        rand_in = 8'h67;
        tick    = 1'b1;
        step();
        tick   = 1'b0;
        enable = 1'b0;
        step();
        check("drop_row_out", 32'(row_out), 32'h00);
        check("drop_row_valid", 32'(row_valid), 32'd0);
        check("drop_state", 32'(u_dut.state), 32'(IDLE));
        check("drop_count_held", 32'(spawn_count), 32'(m_count));
        m_cool = 0;
        step();
        check("drop_no_valid", 32'(row_valid), 32'd0);

        enable = 1'b1;
        step();
        do_tick(8'h67, 3);
        check("reenable_spawn", 32'(row_out), 32'h80);

        // Reset asserted while in EMIT.
        level   = 2'd3;
        rand_in = 8'h99;
        tick    = 1'b1;
        step();
        tick = 1'b0;
        step();
        check("emit_state", 32'(u_dut.state), 32'(EMIT));
        rst = 1'b1;
        #1;
        check("midrst_row_out", 32'(row_out), 32'h00);
        check("midrst_row_valid", 32'(row_valid), 32'd0);
        check("midrst_spawn_count", 32'(spawn_count), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        m_count = 0;
        m_cool  = 0;
        step();
        rst = 1'b0;
        step();

        // Saturation: zero-cooldown instance spawns on every tick at level 3.
        for (int i = 0; i < 300; i++) begin
            do_tick(8'($urandom), 3);
            if (i == 199) check("cd0_count_200", 32'(b_spawn_count), 32'd200);
        end
        check("cd0_count_sat", 32'(b_spawn_count), 32'd255);
        check("main_count", 32'(spawn_count), 32'(m_count));

        repeat (5) step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
